// File: rtl/pulse_seq_pkg.sv
// Shared types and defaults for the spin-echo pulse sequencer.
// The optional receiver gate is enabled with the RX_GATE_EN macro.

package pulse_seq_pkg;

    localparam int CNT_W_DEF       = 24;
    localparam int N_W_DEF         = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int GUARD           = 2;

    typedef enum logic [2:0] {
        IDLE,
        DEAD,
        P90,
        TAU,
        P180,
        ECHO
    } state_t;

    function automatic logic is_pulse(input state_t s);
        return (s == P90) || (s == P180);
    endfunction

endpackage

// File: rtl/pulse_sequencer_trig_sync.sv
// Trigger synchroniser followed by a rising-edge detector.
// The output is a one-cycle pulse.

module trig_sync
    import pulse_seq_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic trig_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], trig};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Reset clears the whole chain, so an edge still in flight is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign trig_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pulse_sequencer.sv
// Spin-echo RF pulse sequencer: dead time, pi/2 pulse, then n_echo pi pulses with echo windows.
// Define RX_GATE_EN to add the rx_gate output, which opens inside each echo window.

module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int N_W         = N_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic             abort,
    input  logic [CNT_W-1:0] dead_cycles,
    input  logic [CNT_W-1:0] pi2_cycles,
    input  logic [CNT_W-1:0] tau_cycles,
    input  logic [N_W-1:0]   n_echo,
    output logic             rf,
    output logic             busy,
    output logic             done,
`ifdef RX_GATE_EN
    output logic [N_W-1:0]   echo_cnt,
    output logic             rx_gate
`else
    output logic [N_W-1:0]   echo_cnt
`endif
);

    localparam int W1 = CNT_W + 1;

    logic trig_rise;

    state_t           state_q;
    state_t           state_d;
    logic [W1-1:0]    cnt_q;
    logic [W1-1:0]    cnt_d;
    logic [CNT_W-1:0] pi2_q;
    logic [CNT_W-1:0] pi2_d;
    logic [CNT_W-1:0] tau_q;
    logic [CNT_W-1:0] tau_d;
    logic [N_W-1:0]   n_q;
    logic [N_W-1:0]   n_d;
    logic [N_W-1:0]   echo_cnt_q;
    logic [N_W-1:0]   echo_cnt_d;
    logic             rf_q;
    logic             rf_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    logic [W1-1:0]    pi2_last;
    logic [W1-1:0]    pi_last;
    logic [W1-1:0]    tau_last;
    logic [W1-1:0]    echo_last;
    logic [N_W:0]     echo_inc;
    logic             cfg_ok;

    trig_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_trig_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig     (trig),
        .trig_rise(trig_rise)
    );

    // Counter reload values are length-1: a state leaves on the cycle its counter reads zero.
    // Doubled lengths use the extra counter bit so 2*pi2 and 2*tau cannot wrap.
    always_comb begin
        pi2_last  = W1'(pi2_q) - W1'(1);
        pi_last   = {pi2_q, 1'b0} - W1'(1);
        tau_last  = W1'(tau_q) - W1'(1);
        echo_last = {tau_q, 1'b0} - W1'(1);
        echo_inc  = {1'b0, echo_cnt_q} + (N_W+1)'(1);
        cfg_ok    = (pi2_cycles != '0) && (n_echo != '0);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pi2_d      = pi2_q;
        tau_d      = tau_q;
        n_d        = n_q;
        echo_cnt_d = echo_cnt_q;
        done_d     = 1'b0;

        if (state_q == IDLE) begin
            // The dead time goes straight into the counter, so it needs no latch of its own.
            if (trig_rise && cfg_ok) begin
                pi2_d      = pi2_cycles;
                tau_d      = tau_cycles;
                n_d        = n_echo;
                echo_cnt_d = '0;
                if (dead_cycles != '0) begin
                    state_d = DEAD;
                    cnt_d   = W1'(dead_cycles) - W1'(1);
                end else begin
                    state_d = P90;
                    cnt_d   = W1'(pi2_cycles) - W1'(1);
                end
            end
        end else if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W1'(1);
        end else begin
            case (state_q)
                DEAD: begin
                    state_d = P90;
                    cnt_d   = pi2_last;
                end
                P90: begin
                    if (tau_q != '0) begin
                        state_d = TAU;
                        cnt_d   = tau_last;
                    end else begin
                        state_d = P180;
                        cnt_d   = pi_last;
                    end
                end
                TAU: begin
                    state_d = P180;
                    cnt_d   = pi_last;
                end
                P180: begin
                    echo_cnt_d = echo_inc[N_W-1:0];
                    if (tau_q != '0) begin
                        state_d = ECHO;
                        cnt_d   = echo_last;
                    end else if (echo_inc < {1'b0, n_q}) begin
                        state_d = P180;
                        cnt_d   = pi_last;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
                ECHO: begin
                    if (echo_cnt_q < n_q) begin
                        state_d = P180;
                        cnt_d   = pi_last;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        rf_d   = is_pulse(state_d);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pi2_q      <= '0;
            tau_q      <= '0;
            n_q        <= '0;
            echo_cnt_q <= '0;
            rf_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pi2_q      <= pi2_d;
            tau_q      <= tau_d;
            n_q        <= n_d;
            echo_cnt_q <= echo_cnt_d;
            rf_q       <= rf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rf       = rf_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign echo_cnt = echo_cnt_q;

`ifdef RX_GATE_EN
    logic          rx_gate_q;
    logic          rx_gate_d;
    logic [W1:0]   gate_pos;

    // Open only once GUARD cycles have elapsed in the window and close GUARD cycles before its end.
    always_comb begin
        gate_pos  = {1'b0, cnt_d} + (W1+1)'(GUARD);
        rx_gate_d = (state_d == ECHO)
                    && (cnt_d >= W1'(GUARD))
                    && (gate_pos < {1'b0, tau_q, 1'b0});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_gate_q <= 1'b0;
        end else begin
            rx_gate_q <= rx_gate_d;
        end
    end

    assign rx_gate = rx_gate_q;
`endif

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: table of shot configurations plus abort/reset/invalid cases.
// Covers the rx_gate output as well when RX_GATE_EN is defined.

module tb_pulse_sequencer;

    localparam int CNT_W = 24;
    localparam int N_W   = 8;
    localparam int MAXC  = 300;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             trig;
    logic             abort;
    logic [CNT_W-1:0] dead_cycles;
    logic [CNT_W-1:0] pi2_cycles;
    logic [CNT_W-1:0] tau_cycles;
    logic [N_W-1:0]   n_echo;
    logic             rf;
    logic             busy;
    logic             done;
    logic [N_W-1:0]   echo_cnt;
`ifdef RX_GATE_EN
    logic             rx_gate;
`endif

    int checks   = 0;
    int failures = 0;
    int cap_len  = 0;
    bit rf_log   [MAXC];
    bit busy_log [MAXC];
    bit done_log [MAXC];
    bit rx_log   [MAXC];

    typedef struct {
        int dead;
        int pi2;
        int tau;
        int n;
        int exp_done;
        int exp_rf;
        int exp_first;
        int exp_echo;
    } vec_t;

    vec_t vecs[6];

    int probe_cyc [12] = '{9, 10, 13, 14, 33, 34, 41, 42, 81, 82, 89, 90};
    int probe_val [12] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};

    always #5 clk = ~clk;

    pulse_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig       (trig),
        .abort      (abort),
        .dead_cycles(dead_cycles),
        .pi2_cycles (pi2_cycles),
        .tau_cycles (tau_cycles),
        .n_echo     (n_echo),
        .rf         (rf),
        .busy       (busy),
        .done       (done),
`ifdef RX_GATE_EN
        .echo_cnt   (echo_cnt),
        .rx_gate    (rx_gate)
`else
        .echo_cnt   (echo_cnt)
`endif
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Called on a negedge; returns how many negedges until busy was first seen (-1 if never).
    task automatic applyStimulus(input int d, input int p, input int t, input int n,
                                 input bit abort_with_trig, output int lat);
        dead_cycles = CNT_W'(d);
        pi2_cycles  = CNT_W'(p);
        tau_cycles  = CNT_W'(t);
        n_echo      = N_W'(n);
        trig        = 1'b1;
        lat         = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (busy) begin
                lat = i;
                break;
            end
            abort = abort_with_trig && (i == 2);
        end
        abort = 1'b0;
        trig  = 1'b0;
    endtask

    task automatic captureShot(input int ncyc, input int abort_at, input int retrig_at,
                               input int cfg_at);
        cap_len = ncyc;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge clk);
            rf_log[k]   = rf;
            busy_log[k] = busy;
            done_log[k] = done;
`ifdef RX_GATE_EN
            rx_log[k]   = rx_gate;
`else
            rx_log[k]   = 1'b0;
`endif
            abort = (k == abort_at);
            if (k == retrig_at) trig = 1'b1;
            if (k == retrig_at + 4) trig = 1'b0;
            if (k == cfg_at) begin
                dead_cycles = 24'd7;
                pi2_cycles  = 24'd9;
                tau_cycles  = 24'd1;
                n_echo      = 8'd5;
            end
        end
        abort = 1'b0;
        trig  = 1'b0;
    endtask

    function automatic bit expRf(input int k, input vec_t v);
        if (k >= v.dead && k < v.dead + v.pi2) return 1'b1;
        for (int i = 0; i < v.n; i++) begin
            int s = v.dead + v.pi2 + v.tau + i * (2 * v.pi2 + 2 * v.tau);
            if (k >= s && k < s + 2 * v.pi2) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic analyzeShot(input vec_t v, input string tag);
        int done_at   = -1;
        int done_cnt  = 0;
        int rf_cnt    = 0;
        int first_rf  = -1;
        int busy_cnt  = 0;
        int win_err   = 0;
        int overlap   = 0;
        for (int k = 0; k < cap_len; k++) begin
            if (done_log[k]) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (rf_log[k]) begin
                rf_cnt++;
                if (first_rf < 0) first_rf = k;
            end
            if (busy_log[k]) busy_cnt++;
            if (rf_log[k] != expRf(k, v)) win_err++;
            if (rf_log[k] && rx_log[k]) overlap++;
        end
        checkOutput({tag, "_done_at"},  done_at,      v.exp_done);
        checkOutput({tag, "_done_cnt"}, done_cnt,     1);
        checkOutput({tag, "_busy_len"}, busy_cnt,     v.exp_done);
        checkOutput({tag, "_rf_cnt"},   rf_cnt,       v.exp_rf);
        checkOutput({tag, "_rf_first"}, first_rf,     v.exp_first);
        checkOutput({tag, "_rf_win"},   win_err,      0);
        checkOutput({tag, "_rx_rf"},    overlap,      0);
        checkOutput({tag, "_echo"},     int'(echo_cnt), v.exp_echo);
    endtask

    initial begin
        int lat;
        int seen;
        int cnt;

        vecs[0] = '{dead: 10, pi2: 4, tau: 20, n: 2, exp_done: 130, exp_rf: 20, exp_first: 10, exp_echo: 2};
        vecs[1] = '{dead: 0,  pi2: 3, tau: 0,  n: 1, exp_done: 9,   exp_rf: 9,  exp_first: 0,  exp_echo: 1};
        vecs[2] = '{dead: 5,  pi2: 1, tau: 1,  n: 3, exp_done: 19,  exp_rf: 7,  exp_first: 5,  exp_echo: 3};
        vecs[3] = '{dead: 0,  pi2: 2, tau: 3,  n: 2, exp_done: 25,  exp_rf: 10, exp_first: 0,  exp_echo: 2};
        vecs[4] = '{dead: 2,  pi2: 1, tau: 0,  n: 4, exp_done: 11,  exp_rf: 9,  exp_first: 2,  exp_echo: 4};
        vecs[5] = '{dead: 1,  pi2: 5, tau: 2,  n: 1, exp_done: 22,  exp_rf: 15, exp_first: 1,  exp_echo: 1};

        rst_n       = 1'b0;
        trig        = 1'b0;
        abort       = 1'b0;
        dead_cycles = '0;
        pi2_cycles  = '0;
        tau_cycles  = '0;
        n_echo      = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_rf",   int'(rf),       0);
        checkOutput("reset_busy", int'(busy),     0);
        checkOutput("reset_done", int'(done),     0);
        checkOutput("reset_echo", int'(echo_cnt), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        checkOutput("idle_abort_busy", int'(busy), 0);

        $display("[TB] table-driven shots");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].dead, vecs[i].pi2, vecs[i].tau, vecs[i].n, 1'b0, lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, 3);
            captureShot(vecs[i].exp_done + 4, -1, -1, -1);
            analyzeShot(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        $display("[TB] invalid configurations");
        applyStimulus(10, 0, 20, 2, 1'b0, lat);
        checkOutput("pi2_zero_latency", lat, -1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || rf || done) seen++;
        end
        checkOutput("pi2_zero_activity", seen, 0);
        checkOutput("pi2_zero_echo", int'(echo_cnt), 1);
        applyStimulus(10, 3, 20, 0, 1'b0, lat);
        checkOutput("n_zero_latency", lat, -1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || rf || done) seen++;
        end
        checkOutput("n_zero_activity", seen, 0);
        checkOutput("n_zero_echo", int'(echo_cnt), 1);

        $display("[TB] retrigger and config change during a shot");
        applyStimulus(10, 4, 20, 2, 1'b0, lat);
        checkOutput("retrig_latency", lat, 3);
        captureShot(134, -1, 50, 20);
        analyzeShot(vecs[0], "retrig");
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("probe_rf_c%0d", probe_cyc[i]),
                        int'(rf_log[probe_cyc[i]]), probe_val[i]);
        end
`ifdef RX_GATE_EN
        cnt = 0;
        for (int k = 0; k < 134; k++) begin
            if (rx_log[k] != ((k >= 44 && k < 80) || (k >= 92 && k < 128))) cnt++;
        end
        checkOutput("rx_gate_windows", cnt, 0);
`endif
        @(negedge clk);
        applyStimulus(10, 4, 20, 2, 1'b0, lat);
        checkOutput("after_done_latency", lat, 3);
        captureShot(134, -1, -1, -1);
        analyzeShot(vecs[0], "after_done");
        @(negedge clk);

        $display("[TB] abort and trigger in the same idle cycle");
        applyStimulus(0, 3, 0, 1, 1'b1, lat);
        checkOutput("abort_trig_latency", lat, 3);
        captureShot(13, -1, -1, -1);
        analyzeShot(vecs[1], "abort_trig");
        @(negedge clk);

        $display("[TB] abort during first pi pulse");
        applyStimulus(10, 4, 20, 2, 1'b0, lat);
        captureShot(140, 36, -1, -1);
        checkOutput("abort180_rf_before", int'(rf_log[36]),   1);
        checkOutput("abort180_rf_after",  int'(rf_log[37]),   0);
        checkOutput("abort180_busy_after", int'(busy_log[37]), 0);
        cnt = 0;
        seen = 0;
        for (int k = 0; k < 140; k++) begin
            if (busy_log[k]) cnt++;
            if (done_log[k]) seen++;
        end
        checkOutput("abort180_busy_len", cnt, 37);
        checkOutput("abort180_done", seen, 0);
        checkOutput("abort180_echo", int'(echo_cnt), 0);
        @(negedge clk);

        $display("[TB] abort on last echo cycle");
        applyStimulus(10, 4, 20, 2, 1'b0, lat);
        captureShot(140, 129, -1, -1);
        cnt = 0;
        seen = 0;
        for (int k = 0; k < 140; k++) begin
            if (busy_log[k]) cnt++;
            if (done_log[k]) seen++;
        end
        checkOutput("abort_last_busy_len", cnt, 130);
        checkOutput("abort_last_done", seen, 0);
        checkOutput("abort_last_echo", int'(echo_cnt), 2);
        @(negedge clk);

        $display("[TB] reset during pi/2 pulse");
        applyStimulus(10, 4, 20, 2, 1'b0, lat);
        repeat (10) @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_rf_before", int'(rf), 1);
        #2;
        rst_n = 1'b0;
        trig  = 1'b0;
        #1;
        checkOutput("rst_mid_rf_async",   int'(rf),   0);
        checkOutput("rst_mid_busy_async", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || rf || done) seen++;
        end
        checkOutput("rst_no_pending_shot", seen, 0);
        checkOutput("rst_echo", int'(echo_cnt), 0);
        applyStimulus(5, 1, 1, 3, 1'b0, lat);
        checkOutput("rst_new_latency", lat, 3);
        captureShot(23, -1, -1, -1);
        analyzeShot(vecs[2], "rst_new");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
